// File: rtl/rvx_signature_checker.sv
// End-of-test monitor: waits for the halt write, then walks the signature region
// through a read port and compares each word against a golden ROM.
module rvx_signature_checker #(
    parameter int                         ADDRESS_WIDTH      = 32,
    parameter logic [31:0]                HALT_ADDRESS       = 32'h00001000,
    parameter logic [31:0]                HALT_VALUE         = 32'h00000001,
    parameter logic [ADDRESS_WIDTH-1:0]   SIG_BEGIN_POINTER  = 32'h00001FFC,
    parameter logic [ADDRESS_WIDTH-1:0]   SIG_END_POINTER    = 32'h00001FF8,
    parameter int                         GOLDEN_DEPTH       = 2048,
    parameter int                         TIMEOUT_CYCLES     = 500000,
    parameter int                         COUNT_WIDTH        = 16,
    localparam int                        GOLDEN_INDEX_WIDTH = $clog2(GOLDEN_DEPTH)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [31:0]                   dbus_address,
    input  logic [31:0]                   dbus_wdata,
    input  logic                          dbus_wrequest,
    output logic [ADDRESS_WIDTH-1:0]      mem_address,
    output logic                          mem_rrequest,
    input  logic [31:0]                   mem_rdata,
    input  logic                          mem_rresponse,
    output logic [GOLDEN_INDEX_WIDTH-1:0] golden_index,
    input  logic [31:0]                   golden_rdata,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic                          timeout,
    output logic                          length_error,
    output logic [COUNT_WIDTH-1:0]        mismatch_count,
    output logic [GOLDEN_INDEX_WIDTH-1:0] first_mismatch_index,
    output logic [31:0]                   first_mismatch_actual,
    output logic [31:0]                   first_mismatch_expected
);
    localparam int WW          = ADDRESS_WIDTH - 2;
    localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [WW-1:0]          DEPTH_W    = WW'(GOLDEN_DEPTH);

    typedef enum logic [3:0] {
        IDLE, RUN, RD_BEGIN_REQ, RD_BEGIN_WAIT, RD_END_REQ, RD_END_WAIT,
        CHECK_REQ, CHECK_WAIT, DONE
    } state_t;

    // Exposed by name so checkers can bind to the current FSM state.
    state_t state, state_next;

    logic [TIMER_WIDTH-1:0] timer;
    logic [WW-1:0]          begin_w, end_w, word;
    logic [WW-1:0]          rd_word, span, word_inc, offset;
    logic                   halt_seen, mismatch;
    logic                   clear, set_timeout, set_length_error;
    logic                   latch_begin, latch_end, word_response;

    assign rd_word   = mem_rdata[ADDRESS_WIDTH-1:2];
    assign span      = rd_word - begin_w;
    assign word_inc  = word + WW'(1);
    assign offset    = word - begin_w;
    assign halt_seen = dbus_wrequest && (dbus_address == HALT_ADDRESS) && (dbus_wdata == HALT_VALUE);
    // 4-state inequality so an X on either side is scored as a mismatch in simulation.
    assign mismatch  = (mem_rdata !== golden_rdata);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next       = state;
        mem_rrequest     = 1'b0;
        clear            = 1'b0;
        set_timeout      = 1'b0;
        set_length_error = 1'b0;
        latch_begin      = 1'b0;
        latch_end        = 1'b0;
        word_response    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (halt_seen) begin
                    state_next = RD_BEGIN_REQ;
                end else if (timer == TIMER_LAST) begin
                    set_timeout = 1'b1;
                    state_next  = DONE;
                end
            end
            RD_BEGIN_REQ: begin
                mem_rrequest = 1'b1;
                state_next   = RD_BEGIN_WAIT;
            end
            RD_BEGIN_WAIT: begin
                if (mem_rresponse) begin
                    latch_begin = 1'b1;
                    state_next  = RD_END_REQ;
                end
            end
            RD_END_REQ: begin
                mem_rrequest = 1'b1;
                state_next   = RD_END_WAIT;
            end
            RD_END_WAIT: begin
                if (mem_rresponse) begin
                    latch_end = 1'b1;
                    if ((rd_word < begin_w) || (span > DEPTH_W)) begin
                        set_length_error = 1'b1;
                        state_next       = DONE;
                    end else if (rd_word == begin_w) begin
                        state_next = DONE;
                    end else begin
                        state_next = CHECK_REQ;
                    end
                end
            end
            CHECK_REQ: begin
                mem_rrequest = 1'b1;
                state_next   = CHECK_WAIT;
            end
            CHECK_WAIT: begin
                if (mem_rresponse) begin
                    word_response = 1'b1;
                    state_next    = (word_inc == end_w) ? DONE : CHECK_REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_address = '0;
        case (state)
            RD_BEGIN_REQ, RD_BEGIN_WAIT: mem_address = {SIG_BEGIN_POINTER[ADDRESS_WIDTH-1:2], 2'b00};
            RD_END_REQ, RD_END_WAIT:     mem_address = {SIG_END_POINTER[ADDRESS_WIDTH-1:2], 2'b00};
            CHECK_REQ, CHECK_WAIT:       mem_address = {word, 2'b00};
            default:                     mem_address = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            timer                   <= '0;
            begin_w                 <= '0;
            end_w                   <= '0;
            word                    <= '0;
            timeout                 <= 1'b0;
            length_error            <= 1'b0;
            mismatch_count          <= '0;
            first_mismatch_index    <= '0;
            first_mismatch_actual   <= '0;
            first_mismatch_expected <= '0;
        end else begin
            if (state == RUN)     timer        <= timer + TIMER_WIDTH'(1);
            if (set_timeout)      timeout      <= 1'b1;
            if (set_length_error) length_error <= 1'b1;
            if (latch_begin)      begin_w      <= rd_word;
            if (latch_end) begin
                end_w <= rd_word;
                word  <= begin_w;
            end
            if (word_response) begin
                if (mismatch) begin
                    // A zero count means no mismatch yet; saturation keeps it non-zero afterwards.
                    if (mismatch_count == '0) begin
                        first_mismatch_index    <= golden_index;
                        first_mismatch_actual   <= mem_rdata;
                        first_mismatch_expected <= golden_rdata;
                    end
                    if (mismatch_count != '1) mismatch_count <= mismatch_count + COUNT_WIDTH'(1);
                end
                word <= word_inc;
            end
        end
    end

    assign golden_index = offset[GOLDEN_INDEX_WIDTH-1:0];
    assign busy         = (state != IDLE) && (state != DONE);
    assign done         = (state == DONE);
    assign pass         = done && !timeout && !length_error && (mismatch_count == '0);
endmodule

// File: tb/tb_rvx_signature_checker.sv
// Directed bench for rvx_signature_checker: memory/ROM models, latency-controlled
// read responder and hand-computed expected results.
module tb_rvx_signature_checker;
    localparam int          GIW       = 11;
    localparam logic [31:0] SIG_BEGIN = 32'h00001FFC;
    localparam logic [31:0] SIG_END   = 32'h00001FF8;

    logic        clock = 1'b0;
    logic        reset, start;
    logic [31:0] dbus_address, dbus_wdata;
    logic        dbus_wrequest;
    logic [31:0] mem_address;
    logic        mem_rrequest;
    logic [31:0] mem_rdata;
    logic        mem_rresponse;
    logic [GIW-1:0] golden_index;
    logic [31:0] golden_rdata;
    logic        busy, done, pass, timeout, length_error;
    logic [7:0]  mismatch_count;
    logic [GIW-1:0] first_mismatch_index;
    logic [31:0] first_mismatch_actual, first_mismatch_expected;

    logic [31:0] mem    [4096];
    logic [31:0] golden [2048];
    logic [31:0] exp_q[$];

    int n_vectors     = 0;
    int n_miscompares = 0;
    int n_check_reads = 0;
    int n_reads       = 0;
    int lat_min       = 1;
    int lat_max       = 1;
    logic [31:0] cur_begin = 32'h0;

    always #5 clock = ~clock;

    assign golden_rdata = golden[golden_index];

    rvx_signature_checker #(
        .TIMEOUT_CYCLES (100),
        .COUNT_WIDTH    (8)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .start                   (start),
        .dbus_address            (dbus_address),
        .dbus_wdata              (dbus_wdata),
        .dbus_wrequest           (dbus_wrequest),
        .mem_address             (mem_address),
        .mem_rrequest            (mem_rrequest),
        .mem_rdata               (mem_rdata),
        .mem_rresponse           (mem_rresponse),
        .golden_index            (golden_index),
        .golden_rdata            (golden_rdata),
        .busy                    (busy),
        .done                    (done),
        .pass                    (pass),
        .timeout                 (timeout),
        .length_error            (length_error),
        .mismatch_count          (mismatch_count),
        .first_mismatch_index    (first_mismatch_index),
        .first_mismatch_actual   (first_mismatch_actual),
        .first_mismatch_expected (first_mismatch_expected)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Read responder: answers each request after lat_min..lat_max cycles and
    // checks the address sequence, golden index, request pulse and address hold.
    initial begin : responder
        logic [31:0]    a;
        logic [GIW-1:0] gi;
        int             lat;
        bit             aborted;
        mem_rresponse = 1'b0;
        mem_rdata     = 32'h0BADF00D;
        forever begin
            @(negedge clock);
            mem_rresponse = 1'b0;
            mem_rdata     = 32'h0BADF00D;
            if (mem_rrequest && !reset) begin
                a  = mem_address;
                gi = golden_index;
                n_reads++;
                if (exp_q.size() == 0) check("read_q_size", 32'(exp_q.size()), 32'd1);
                else                   check("read_addr", a, exp_q.pop_front());
                if (a != SIG_BEGIN && a != SIG_END) begin
                    n_check_reads++;
                    check("golden_index", 32'(gi), 32'(GIW'((a - cur_begin) >> 2)));
                end
                lat     = $urandom_range(lat_max, lat_min);
                aborted = 1'b0;
                for (int i = 0; i < lat; i++) begin
                    @(negedge clock);
                    if (reset) aborted = 1'b1;
                    if (!aborted) begin
                        check("req_pulse", 32'(mem_rrequest), 32'd0);
                        check("addr_hold", mem_address, a);
                    end
                end
                if (!aborted) begin
                    mem_rresponse = 1'b1;
                    mem_rdata     = mem[a[13:2]];
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    task automatic halt_write();
        @(negedge clock);
        dbus_wrequest = 1'b1; dbus_address = 32'h00001000; dbus_wdata = 32'h00000001;
        @(negedge clock);
        dbus_wrequest = 1'b0; dbus_address = 32'h0; dbus_wdata = 32'h0;
    endtask

    // Program the pointers and queue the expected read address sequence.
    task automatic setup_region(input logic [31:0] b, input logic [31:0] e, input int n_words);
        mem[SIG_BEGIN[13:2]] = b;
        mem[SIG_END[13:2]]   = e;
        cur_begin     = b;
        n_check_reads = 0;
        n_reads       = 0;
        exp_q.delete();
        exp_q.push_back(SIG_BEGIN);
        exp_q.push_back(SIG_END);
        for (int i = 0; i < n_words; i++) exp_q.push_back(b + 32'(4 * i));
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            @(negedge clock);
            cycles++;
        end
        check("done", 32'(done), 32'd1);
    endtask

    initial begin : main
        int cycles;
        reset = 1'b1; start = 1'b0;
        dbus_wrequest = 1'b0; dbus_address = 32'h0; dbus_wdata = 32'h0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        for (int i = 0; i < 2048; i++) golden[i] = 32'hA5000000 ^ (32'(i) * 32'h00010203);
        golden[2] = 32'hDEADBEEF;
        repeat (3) @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_req", 32'(mem_rrequest), 32'd0);
        check("rst_addr", mem_address, 32'd0);
        check("rst_count", 32'(mismatch_count), 32'd0);
        reset = 1'b0;

        // Four matching words, single-cycle responses: done 12 cycles after halt.
        for (int i = 0; i < 4; i++) mem[(32'h2000 >> 2) + i] = golden[i];
        setup_region(32'h2000, 32'h2010, 4);
        lat_min = 1; lat_max = 1;
        pulse_start();
        check("t1_busy", 32'(busy), 32'd1);
        repeat (5) @(negedge clock);
        halt_write();
        wait_done(100, cycles);
        check("t1_latency", 32'(cycles), 32'd12);
        check("t1_pass", 32'(pass), 32'd1);
        check("t1_count", 32'(mismatch_count), 32'd0);
        check("t1_reads", 32'(n_check_reads), 32'd4);
        check("t1_q_left", 32'(exp_q.size()), 32'd0);

        // Word 2 corrupted, random response stalls.
        mem[(32'h2000 >> 2) + 2] = 32'h12345678;
        setup_region(32'h2000, 32'h2010, 4);
        lat_min = 1; lat_max = 5;
        pulse_start();
        halt_write();
        wait_done(200, cycles);
        check("t2_pass", 32'(pass), 32'd0);
        check("t2_count", 32'(mismatch_count), 32'd1);
        check("t2_fm_index", 32'(first_mismatch_index), 32'd2);
        check("t2_fm_actual", first_mismatch_actual, 32'h12345678);
        check("t2_fm_expect", first_mismatch_expected, 32'hDEADBEEF);

        // No halt (only near-miss writes): timeout exactly 100 cycles after start.
        setup_region(32'h3000, 32'h3000, 0);
        lat_min = 1; lat_max = 1;
        pulse_start();
        check("t3_cleared", 32'(mismatch_count), 32'd0);
        for (int k = 1; k < 100; k++) begin
            dbus_wrequest = (k == 10) || (k == 20);
            dbus_address  = (k == 20) ? 32'h00001004 : 32'h00001000;
            dbus_wdata    = (k == 10) ? 32'h00000002 : 32'h00000001;
            @(negedge clock);
        end
        dbus_wrequest = 1'b0;
        check("t3_done_99", 32'(done), 32'd0);
        @(negedge clock);
        check("t3_done_100", 32'(done), 32'd1);
        check("t3_timeout", 32'(timeout), 32'd1);
        check("t3_pass", 32'(pass), 32'd0);
        check("t3_reads", 32'(n_reads), 32'd0);

        // Halt in the terminal-count cycle wins; empty signature passes.
        setup_region(32'h3000, 32'h3000, 0);
        pulse_start();
        check("t4_timeout_clr", 32'(timeout), 32'd0);
        for (int k = 1; k <= 100; k++) begin
            dbus_wrequest = (k == 100);
            dbus_address  = 32'h00001000;
            dbus_wdata    = 32'h00000001;
            @(negedge clock);
        end
        dbus_wrequest = 1'b0;
        check("t4_busy", 32'(busy), 32'd1);
        wait_done(50, cycles);
        check("t4_timeout", 32'(timeout), 32'd0);
        check("t4_pass", 32'(pass), 32'd1);
        check("t4_check_reads", 32'(n_check_reads), 32'd0);

        // Signature one word longer than the golden ROM.
        setup_region(32'h3000, 32'h3000 + 32'd4 * 32'd2049, 0);
        pulse_start();
        halt_write();
        wait_done(50, cycles);
        check("t5_len_err", 32'(length_error), 32'd1);
        check("t5_pass", 32'(pass), 32'd0);
        check("t5_check_reads", 32'(n_check_reads), 32'd0);

        // begin > end.
        setup_region(32'h3004, 32'h3000, 0);
        pulse_start();
        halt_write();
        wait_done(50, cycles);
        check("t6_len_err", 32'(length_error), 32'd1);
        check("t6_pass", 32'(pass), 32'd0);

        // 300 mismatching words saturate the 8-bit counter.
        for (int i = 0; i < 300; i++) mem[(32'h3000 >> 2) + i] = ~golden[i];
        setup_region(32'h3000, 32'h3000 + 32'd4 * 32'd300, 300);
        pulse_start();
        halt_write();
        wait_done(2000, cycles);
        check("t7_len_err", 32'(length_error), 32'd0);
        check("t7_count", 32'(mismatch_count), 32'd255);
        check("t7_fm_index", 32'(first_mismatch_index), 32'd0);
        check("t7_fm_actual", first_mismatch_actual, ~golden[0]);
        check("t7_check_reads", 32'(n_check_reads), 32'd300);

        // Reset while a check read is outstanding, then a clean run.
        setup_region(32'h2000, 32'h2010, 4);
        mem[(32'h2000 >> 2) + 2] = golden[2];
        lat_min = 8; lat_max = 8;
        pulse_start();
        halt_write();
        cycles = 0;
        while (n_check_reads == 0 && cycles < 200) begin
            @(negedge clock);
            cycles++;
        end
        check("t8_reached_check", 32'(n_check_reads), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("t8_busy", 32'(busy), 32'd0);
        check("t8_done", 32'(done), 32'd0);
        check("t8_req", 32'(mem_rrequest), 32'd0);
        reset = 1'b0;
        repeat (15) @(negedge clock);
        setup_region(32'h2000, 32'h2010, 4);
        lat_min = 1; lat_max = 1;
        pulse_start();
        halt_write();
        wait_done(100, cycles);
        check("t8_pass", 32'(pass), 32'd1);
        check("t8_count", 32'(mismatch_count), 32'd0);
        check("t8_reads", 32'(n_check_reads), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
